// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the RV32I pipeline (IF, ID, EX, hazard unit).
//   XLEN         - architectural register / address width
//   NOP_INSTR    - canonical NOP (addi x0, x0, 0), used for bubbles and unmapped fetches
//   IMEM_DEPTH   - default instruction ROM depth in 32-bit words
//   IMEM_ADDR_W  - word-index width for the default ROM depth
//   bringup_word - compiled-in "program.hex" image, indexed by word
package riscv_pkg;

  localparam int          XLEN        = 32;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          IMEM_DEPTH  = 256;
  localparam int          IMEM_ADDR_W = $clog2(IMEM_DEPTH);

  // Bring-up program: x1=5; x3=x1+x2; sw x2,0(x1); lw x5,0(x1).
  // Every other word reads as NOP.
  function automatic logic [31:0] bringup_word(input logic [31:0] idx);
    logic [31:0] w;
    case (idx)
      32'd0:   w = 32'h0050_0093;
      32'd1:   w = 32'h0020_81b3;
      32'd2:   w = 32'h0020_a023;
      32'd3:   w = 32'h0000_a283;
      default: w = NOP_INSTR;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/if_stage_imem_rom.sv
// imem_rom: combinational instruction ROM.
//   DEPTH  - number of 32-bit words (power of 2)
//   FILE   - image name; "program.hex" selects the compiled-in bring-up image,
//            any other name gives an all-NOP ROM
//   i_addr - word index (in)
//   o_data - instruction word at i_addr (out, combinational)
module imem_rom
  import riscv_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter     FILE  = "program.hex",
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   o_data
);

  localparam bit USE_BRINGUP = (FILE == "program.hex");

  logic [31:0] w_idx;

  assign w_idx = {{(32 - AW){1'b0}}, i_addr};

  always_comb begin
    o_data = NOP_INSTR;
    if (USE_BRINGUP) o_data = bringup_word(w_idx);
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I fetch stage. Holds the PC, reads imem_rom combinationally
// and drives the IF/ID register consumed by the decode stage.
//   clk, reset        - clock; asynchronous active-low reset
//   stall             - hold PC and IF/ID
//   PCSrc, PCTarget   - redirect request and target (wins over stall); the
//                       IF/ID slot is flushed to a NOP bubble
//   instruction, PC, PC_plus4, if_valid - IF/ID register contents
//   misalign_err      - sticky flag, set by a redirect with PCTarget[1:0]!=0
// Optional build macro IF_STAGE_PERF_CNT_EN adds perf_fetch_cnt,
// perf_stall_cnt and perf_flush_cnt (wrapping 32-bit event counters).
// Handshake: there is no valid/ready pair; stall is the only backpressure,
// and if_valid=0 marks the IF/ID slot as a bubble.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 256,
  parameter              IMEM_FILE  = "program.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        if_valid,
  output logic        misalign_err
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int ROM_ADDR_W = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0]       r_pc;
  logic [XLEN-1:0]       r_instr;
  logic [XLEN-1:0]       r_pc_out;
  logic [XLEN-1:0]       r_pc4_out;
  logic                  r_valid;
  logic                  r_err;

  logic [XLEN-1:0]       w_pc_plus4;
  logic [ROM_ADDR_W-1:0] w_word_idx;
  logic [XLEN-1:0]       w_rom_data;
  logic                  w_in_range;
  logic [XLEN-1:0]       w_fetch;
  logic                  w_misaligned;

  // Modulo-2^32 add: FFFF_FFFC wraps to 0 silently.
  assign w_pc_plus4   = r_pc + 32'd4;
  assign w_word_idx   = r_pc[ROM_ADDR_W+1:2];
  // Any address bit above the ROM window means the fetch is unmapped.
  assign w_in_range   = ((r_pc >> (ROM_ADDR_W + 2)) == '0);
  assign w_fetch      = w_in_range ? w_rom_data : NOP_INSTR;
  assign w_misaligned = (PCTarget[1:0] != 2'b00);

  imem_rom #(
    .DEPTH (IMEM_DEPTH),
    .FILE  (IMEM_FILE)
  ) u_imem_rom (
    .i_addr (w_word_idx),
    .o_data (w_rom_data)
  );

  // Priority: reset > redirect > stall > normal fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_pc_out  <= '0;
      r_pc4_out <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else if (PCSrc) begin
      // Flush the wrong-path fetch; target is fetched on the next edge.
      r_pc      <= {PCTarget[31:2], 2'b00};
      r_instr   <= NOP_INSTR;
      r_pc_out  <= '0;
      r_pc4_out <= '0;
      r_valid   <= 1'b0;
      if (w_misaligned) r_err <= 1'b1;
    end else if (!stall) begin
      r_pc      <= w_pc_plus4;
      r_instr   <= w_fetch;
      r_pc_out  <= r_pc;
      r_pc4_out <= w_pc_plus4;
      r_valid   <= 1'b1;
    end
  end

  assign instruction  = r_instr;
  assign PC           = r_pc_out;
  assign PC_plus4     = r_pc4_out;
  assign if_valid     = r_valid;
  assign misalign_err = r_err;

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (PCSrc) begin
      r_flush_cnt <= r_flush_cnt + 32'd1;
    end else if (stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
  assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed bring-up sequence with literal expectations, then
// randomized stall/redirect/reset traffic checked every cycle against a
// behavioural model of the fetch stage.
module tb_if_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          W    = 98;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PCTarget = 32'd0;
  logic [31:0] instruction, PC, PC_plus4;
  logic        if_valid, misalign_err;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  always #5 clk = ~clk;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .instruction  (instruction),
    .PC           (PC),
    .PC_plus4     (PC_plus4),
    .if_valid     (if_valid),
    .misalign_err (misalign_err)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Program image by byte address; anything outside the 1 KiB ROM is a NOP.
  function automatic logic [31:0] image(input logic [31:0] a);
    if (a >= 32'd1024) return NOP;
    case (a)
      32'd0:   return 32'h0050_0093;
      32'd4:   return 32'h0020_81b3;
      32'd8:   return 32'h0020_a023;
      32'd12:  return 32'h0000_a283;
      default: return NOP;
    endcase
  endfunction

  logic [31:0] m_pc = 32'd0, m_instr = NOP, m_pco = 32'd0, m_pc4 = 32'd0;
  logic        m_valid = 1'b0, m_err = 1'b0;
  logic [31:0] m_nfetch = 0, m_nstall = 0, m_nflush = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'd0; m_instr = NOP; m_pco = 32'd0; m_pc4 = 32'd0;
      m_valid = 1'b0; m_err = 1'b0;
      m_nfetch = 0; m_nstall = 0; m_nflush = 0;
    end else if (PCSrc) begin
      m_pc = PCTarget & 32'hFFFF_FFFC;
      m_instr = NOP; m_pco = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
      if (PCTarget % 4 != 0) m_err = 1'b1;
      m_nflush = m_nflush + 1;
    end else if (stall) begin
      m_nstall = m_nstall + 1;
    end else begin
      m_instr = image(m_pc); m_pco = m_pc; m_pc4 = m_pc + 4; m_valid = 1'b1;
      m_pc = m_pc + 4;
      m_nfetch = m_nfetch + 1;
    end
    exp_q.push_back({m_valid, m_instr, m_pco, m_pc4, m_err});
  end

  // ---------------- scoreboard compare ----------------
  logic [W-1:0] e;
  always @(negedge clk) begin
    if (cmp_en && exp_q.size() > 0) begin
      while (exp_q.size() > 1) exp_q.delete(0);
      e = exp_q.pop_front();
      chk("sb_valid", {31'd0, if_valid},     {31'd0, e[97]});
      chk("sb_instr", instruction,           e[96:65]);
      chk("sb_pc",    PC,                    e[64:33]);
      chk("sb_pc4",   PC_plus4,              e[32:1]);
      chk("sb_err",   {31'd0, misalign_err}, {31'd0, e[0]});
`ifdef IF_STAGE_PERF_CNT_EN
      chk("sb_fetch_cnt", perf_fetch_cnt, m_nfetch);
      chk("sb_stall_cnt", perf_stall_cnt, m_nstall);
      chk("sb_flush_cnt", perf_flush_cnt, m_nflush);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic s, input logic p, input logic [31:0] t);
    stall = s; PCSrc = p; PCTarget = t;
  endtask

  task automatic expect_ifid(input string name, input logic [31:0] pc,
                             input logic [31:0] ins, input logic v);
    chk({name, "_pc"},    PC,                {pc});
    chk({name, "_instr"}, instruction,       ins);
    chk({name, "_valid"}, {31'd0, if_valid}, {31'd0, v});
  endtask

  task automatic expect_reset(input string name);
    chk({name, "_instr"}, instruction,           NOP);
    chk({name, "_pc"},    PC,                    32'd0);
    chk({name, "_pc4"},   PC_plus4,              32'd0);
    chk({name, "_valid"}, {31'd0, if_valid},     32'd0);
    chk({name, "_err"},   {31'd0, misalign_err}, 32'd0);
`ifdef IF_STAGE_PERF_CNT_EN
    chk({name, "_fcnt"}, perf_fetch_cnt, 32'd0);
    chk({name, "_scnt"}, perf_stall_cnt, 32'd0);
    chk({name, "_lcnt"}, perf_flush_cnt, 32'd0);
`endif
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0, 1:    return 32'($urandom_range(0, 40));
      2:       return 32'd1012 + 32'($urandom_range(0, 20));
      default: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    // Reset held for three edges.
    drive(0, 0, 0);
    repeat (3) tick();
    expect_reset("rst_hold");
    reset = 1'b1;
    cmp_en = 1'b1;

    // Straight-line fetch of the image.
    tick(); expect_ifid("f0", 32'd0, 32'h0050_0093, 1);
    chk("f0_pc4", PC_plus4, 32'd4);
    tick(); expect_ifid("f1", 32'd4, 32'h0020_81b3, 1);

    // Stall two edges at PC=4, then resume at 8.
    drive(1, 0, 0);
    tick(); expect_ifid("st0", 32'd4, 32'h0020_81b3, 1);
    tick(); expect_ifid("st1", 32'd4, 32'h0020_81b3, 1);
    drive(0, 0, 0);
    tick(); expect_ifid("st_res", 32'd8, 32'h0020_a023, 1);

    // Redirect to 0 while PC=8.
    drive(0, 1, 32'd0);
    tick(); expect_ifid("rd_bub", 32'd0, NOP, 0);
    drive(0, 0, 0);
    tick(); expect_ifid("rd_tgt", 32'd0, 32'h0050_0093, 1);

    // Redirect and stall together: redirect wins.
    drive(1, 1, 32'd12);
    tick(); expect_ifid("rs_bub", 32'd0, NOP, 0);
    drive(0, 0, 0);
    tick(); expect_ifid("rs_tgt", 32'd12, 32'h0000_a283, 1);

    // Misaligned target 6 fetches from 4 and sets the sticky flag.
    drive(0, 1, 32'd6);
    tick(); chk("mis_set", {31'd0, misalign_err}, 32'd1);
    drive(0, 0, 0);
    tick(); expect_ifid("mis_tgt", 32'd4, 32'h0020_81b3, 1);
    tick(); chk("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Unmapped address returns NOP with if_valid=1.
    drive(0, 1, 32'd1024);
    tick(); drive(0, 0, 0);
    tick(); expect_ifid("oor", 32'd1024, NOP, 1);

    // PC wrap at 2^32.
    drive(0, 1, 32'hFFFF_FFFC);
    tick(); drive(0, 0, 0);
    tick(); expect_ifid("wrap0", 32'hFFFF_FFFC, NOP, 1);
    chk("wrap0_pc4", PC_plus4, 32'd0);
    tick(); expect_ifid("wrap1", 32'd0, 32'h0050_0093, 1);
    tick(); tick(); tick();
    expect_ifid("at12", 32'd12, 32'h0000_a283, 1);

    // Asynchronous reset mid-cycle.
    reset = 1'b0;
    #1;
    expect_reset("async_rst");
    tick();
    reset = 1'b1;
    tick(); expect_ifid("post_rst", 32'd0, 32'h0050_0093, 1);

    // Randomized traffic; the scoreboard checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 2) begin
        drive(0, 0, 0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end else begin
        drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0), pick_target());
        tick();
      end
    end

    drive(0, 0, 0);
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
